// File: rtl/rev_stream_pkg.sv
// Shared types and defaults for the reverse-stream keyer and matcher.
// Widths here must agree with the matcher's build.
package rev_stream_pkg;

  localparam int DEF_DEPTH     = 16;
  localparam int DEF_KWIDTH    = 16;
  localparam int DEF_DWIDTH    = 16;
  localparam int DEF_SEQ_WIDTH = 8;
  localparam int DEF_NCHUNK    = (DEF_DWIDTH + DEF_KWIDTH - 1) / DEF_KWIDTH;

  typedef struct packed {
    logic [DEF_KWIDTH-1:0]    key;
    logic [DEF_DWIDTH-1:0]    data;
    logic [DEF_SEQ_WIDTH-1:0] seq;
  } keyed_rec_t;

  // XOR of KWIDTH-bit chunks, LSB chunk first, top chunk zero-padded.
  function automatic logic [DEF_KWIDTH-1:0] key_fold(input logic [DEF_DWIDTH-1:0] data);
    logic [DEF_NCHUNK*DEF_KWIDTH-1:0] padded;
    logic [DEF_KWIDTH-1:0]            acc;
    padded = (DEF_NCHUNK*DEF_KWIDTH)'(data);
    acc    = '0;
    for (int c = 0; c < DEF_NCHUNK; c++) begin
      acc = acc ^ padded[c*DEF_KWIDTH +: DEF_KWIDTH];
    end
    return acc;
  endfunction

endpackage

// File: rtl/rev_sync_fifo.sv
// Generic first-word-fall-through FIFO with occupancy count and synchronous flush.
// Full/empty come from the registered count only, so no input reaches them combinationally.
module rev_sync_fifo
  import rev_stream_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = $bits(keyed_rec_t)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_push_acc,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full     = (r_count == FULL_CNT);
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign w_push_ok  = i_push && !o_full && !i_flush;
  assign w_pop_ok   = i_pop && !o_empty && !i_flush;
  assign o_push_acc = w_push_ok;

  // Head is read straight from storage; forced to zero while empty.
  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rev_stream_keyer.sv
// Keys raw words by XOR-folding, tags them with a wrapping sequence number
// and buffers the records for the reverse-stream matcher.
module rev_stream_keyer
  import rev_stream_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int KWIDTH    = DEF_KWIDTH,
  parameter int DWIDTH    = DEF_DWIDTH,
  parameter int SEQ_WIDTH = DEF_SEQ_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_enque_en,
  output logic                   in_valid,
  input  logic [DWIDTH-1:0]      in_data,
  input  logic                   flush,
  input  logic                   out_deque_en,
  output logic                   out_valid,
  output logic [KWIDTH-1:0]      out_key,
  output logic [DWIDTH-1:0]      out_data,
  output logic [SEQ_WIDTH-1:0]   out_seq,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            drop_cnt
);

  localparam int NCHUNK = (DWIDTH + KWIDTH - 1) / KWIDTH;

  typedef struct packed {
    logic [KWIDTH-1:0]    key;
    logic [DWIDTH-1:0]    data;
    logic [SEQ_WIDTH-1:0] seq;
  } rec_t;

  logic [KWIDTH-1:0]    w_key;
  rec_t                 w_wr_rec;
  rec_t                 w_rd_rec;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push_acc;
  logic                 w_drop;
  logic [SEQ_WIDTH-1:0] r_seq;
  logic [15:0]          r_drop_cnt;

  // Default widths share the package fold with the matcher; other widths fold chunk by chunk.
  generate
    if (DWIDTH == DEF_DWIDTH && KWIDTH == DEF_KWIDTH) begin : g_pkg_fold
      assign w_key = key_fold(in_data);
    end else begin : g_gen_fold
      logic [NCHUNK*KWIDTH-1:0] w_data_pad;
      logic [KWIDTH-1:0]        w_fold [NCHUNK+1];
      assign w_data_pad = (NCHUNK*KWIDTH)'(in_data);
      assign w_fold[0]  = '0;
      for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
        assign w_fold[gi+1] = w_fold[gi] ^ w_data_pad[gi*KWIDTH +: KWIDTH];
      end
      assign w_key = w_fold[NCHUNK];
    end
  endgenerate

  assign w_wr_rec = '{key: w_key, data: in_data, seq: r_seq};

  rev_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(rec_t))
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (in_enque_en),
    .i_pop      (out_deque_en),
    .i_flush    (flush),
    .i_wdata    (w_wr_rec),
    .o_rdata    (w_rd_rec),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_push_acc (w_push_acc),
    .o_count    (count)
  );

  assign in_valid  = !w_full;
  assign out_valid = !w_empty;
  assign out_key   = w_rd_rec.key;
  assign out_data  = w_rd_rec.data;
  assign out_seq   = w_rd_rec.seq;
  assign drop_cnt  = r_drop_cnt;
  assign w_drop    = in_enque_en && w_full && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seq      <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push_acc) begin
        r_seq <= r_seq + 1'b1;
      end
      if (w_drop && r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/rev_stream_keyer.md
Name: rev_stream_keyer

Overview:
Upstream feeder for the reverse-stream matcher. It accepts raw data words, derives a KWIDTH match key from each word by XOR-folding, and tags the word with a wrapping sequence number. The {key, data, seq} records are buffered in a first-word-fall-through FIFO. Records are handed downstream to the matcher's enqueue side using the same enqueue/valid handshake style.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
KWIDTH, 16, key width; must match matcher KWIDTH
DWIDTH, 16, data width; must match matcher DWIDTH
SEQ_WIDTH, 8, sequence tag width

Ports:
clk  in  1  single clock
rst  in  1  reset, asynchronous, active-high
in_enque_en  in  1  push request; data sampled on posedge clk
in_valid  out  1  space available (not full)
in_data  in  DWIDTH  word to enqueue
flush  in  1  synchronous FIFO clear
out_deque_en  in  1  pop request from matcher
out_valid  out  1  head record present (not empty)
out_key  out  KWIDTH  key of head record
out_data  out  DWIDTH  data of head record
out_seq  out  SEQ_WIDTH  sequence tag of head record
count  out  $clog2(DEPTH)+1  current occupancy
drop_cnt  out  16  pushes rejected while full; saturating

Behaviour:
- Reset (async, rst=1): pointers, count, seq counter and drop_cnt go to 0. in_valid=1, out_valid=0. out_key, out_data and out_seq read 0.
- Key derivation:
  - Split in_data into ceil(DWIDTH/KWIDTH) KWIDTH-bit chunks, LSB first; zero-pad the top chunk.
  - key = XOR of all chunks.
  - With DWIDTH==KWIDTH, key == data.
- Push: accepted iff in_enque_en && in_valid && !flush.
  - The record stored is {key, in_data, seq_ctr}; seq_ctr then increments, wrapping modulo 2^SEQ_WIDTH.
  - seq_ctr advances only on accepted pushes.
- Rejected push: in_enque_en=1 while full, flush=0.
  - Nothing is stored and seq_ctr is unchanged.
  - drop_cnt increments, saturating at 16'hFFFF.
- Pop: occurs iff out_deque_en && out_valid && !flush; the head advances.
  - out_deque_en while empty is ignored, with no error and no state change.
- Output timing: first-word fall-through.
  - The head record is driven combinationally from storage by the read pointer.
  - A word pushed at edge N gives out_valid=1 after edge N when the FIFO was empty (1-cycle latency).
- Simultaneous push and pop:
  - Not full, not empty: both happen and count is unchanged.
  - Empty: the push happens, the pop is ignored, and count becomes 1.
  - Full: the pop happens, the push is rejected (in_valid is a registered-state full flag with no bypass), and drop_cnt increments.
- flush=1: at the next edge, pointers and count go to 0.
  - Any coincident push or pop is ignored.
  - seq_ctr and drop_cnt are kept.
- in_valid = (count != DEPTH). out_valid = (count != 0). Both are derived from registered count, so there are no combinational paths from inputs to the handshake outputs.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is tracked separately, so full and empty are unambiguous.
- Reset mid-operation: contents are discarded, all state returns to reset values immediately, and storage contents are don't-care.

Decomposition:
- Shared package rev_stream_pkg holds:
  - typedef keyed_rec_t packed {Key[KWIDTH], Data[DWIDTH], Seq[SEQ_WIDTH]}
  - function key_fold(data) returning the XOR-fold
  - the default width constants, shared with the matcher
- One natural sub-module: rev_sync_fifo, a generic FWFT FIFO with count and a flush input, instantiated with keyed_rec_t.
- The keyer top holds key fold, seq counter and drop counter.

Test Plan:
- Reset, then push 16'h1234 one cycle → next cycle out_valid=1, out_key=16'h1234, out_data=16'h1234, out_seq=0, count=1.
- DWIDTH=32, KWIDTH=16: push 32'hA5A5_0F0F → out_key=16'hAAAA. Push 32'h0001_0001 → out_key=16'h0000 and out_seq=1.
- Fill to 16 (seq 0..15), then push 2 more → in_valid=0, drop_cnt=2, count=16. Pop all 16 → seq 0..15 in order, then out_valid=0.
- Full, then push and pop the same cycle → count=16→15, drop_cnt+1. Next push gets seq=16.
- Empty, then push and pop the same cycle → count=1, record present. Pop on empty → no change.
- With 5 entries, assert flush with a coincident push → count=0, out_valid=0. Next accepted push carries seq=5. Assert rst mid-burst → all outputs go to reset values asynchronously.
